// File: rtl/rst_req_pkg.sv
// rst_req_pkg
// Shared encodings for the reset-request block: FSM states, reset-cause codes,
// and a helper that sizes counters from their length parameters.
// No ports.
package rst_req_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAssert = 2'd1,
    StHold   = 2'd2
  } state_e;

  localparam logic [1:0] CauseNone = 2'd0;
  localparam logic [1:0] CauseBtn  = 2'd1;
  localparam logic [1:0] CauseWdt  = 2'd2;
  localparam logic [1:0] CauseSw   = 2'd3;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_req_debounce.sv
// rst_req_debounce
// Two-flop synchronizer followed by a debouncer for an active-low button.
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   i_in_n  - raw asynchronous input (active-low button)
//   o_level - debounced level (1 = released)
//   o_fall  - one-cycle pulse in the first cycle the debounced level reads 0
module rst_req_debounce
  import rst_req_pkg::*;
#(
  parameter int unsigned DEB_LEN = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in_n,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CntW = cnt_width(DEB_LEN);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_LEN - 1);

  logic [1:0]      r_sync;
  logic [CntW-1:0] r_cnt;
  logic            r_level;
  logic            r_fall;
  logic            w_diff;
  logic            w_done;

  // Count consecutive cycles the synchronized input disagrees with the
  // accepted level; the DEB_LEN-th such cycle commits the new level.
  assign w_diff = r_sync[1] ^ r_level;
  assign w_done = w_diff && (r_cnt == CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_in_n};
      r_fall <= w_done & ~r_sync[1];
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/rst_req.sv
// rst_req
// Generates a fixed-length active-high reset request from three sources
// (debounced button, watchdog timeout, software request) and records which
// source caused the last request. Must be clocked from the raw oscillator and
// reset from a source independent of o_rst_req.
// Ports:
//   clk        - raw board oscillator clock
//   rst_n      - asynchronous active-low reset
//   i_btn_n    - raw asynchronous user button, active-low
//   i_sw_req   - single-cycle software reset request
//   i_wdt_en   - watchdog enable level
//   i_wdt_kick - single-cycle watchdog reload
//   o_rst_req  - registered active-high reset request
//   o_cause    - registered last cause: 0 none, 1 button, 2 watchdog, 3 software
module rst_req
  import rst_req_pkg::*;
#(
  parameter int unsigned DEB_LEN   = 50000,
  parameter int unsigned PULSE_LEN = 16,
  parameter int unsigned WDT_LEN   = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_n,
  input  logic       i_sw_req,
  input  logic       i_wdt_en,
  input  logic       i_wdt_kick,
  output logic       o_rst_req,
  output logic [1:0] o_cause
);

  localparam int unsigned PcntW = cnt_width(PULSE_LEN);
  localparam int unsigned WdtW  = cnt_width(WDT_LEN);
  localparam logic [PcntW-1:0] PulseMax = PcntW'(PULSE_LEN - 1);
  localparam logic [WdtW-1:0]  WdtMax   = WdtW'(WDT_LEN - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [PcntW-1:0] r_pcnt;
  logic [PcntW-1:0] w_pcnt_nxt;
  logic [WdtW-1:0]  r_wdt_cnt;
  logic [WdtW-1:0]  w_wdt_nxt;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_nxt;
  logic             r_rst_req;
  logic             w_rst_req_nxt;
  logic             w_btn_level;
  logic             w_btn_fall;
  logic             w_wdt_fire;
  logic             w_idle;

  rst_req_debounce #(
    .DEB_LEN (DEB_LEN)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_in_n  (i_btn_n),
    .o_level (w_btn_level),
    .o_fall  (w_btn_fall)
  );

  assign w_idle = (r_state == StIdle);

  // A kick in the expiry cycle suppresses the event.
  assign w_wdt_fire = w_idle && i_wdt_en && !i_wdt_kick && (r_wdt_cnt == WdtMax);

  always_comb begin
    w_wdt_nxt = r_wdt_cnt;
    if (!w_idle || !i_wdt_en || i_wdt_kick || w_wdt_fire) begin
      w_wdt_nxt = '0;
    end else begin
      w_wdt_nxt = r_wdt_cnt + WdtW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_cause_nxt = r_cause;
    case (r_state)
      StIdle: begin
        if (w_btn_fall || w_wdt_fire || i_sw_req) begin
          w_state_nxt = StAssert;
          w_pcnt_nxt  = PulseMax;
          // Fixed priority: button, then watchdog, then software.
          if (w_btn_fall) begin
            w_cause_nxt = CauseBtn;
          end else if (w_wdt_fire) begin
            w_cause_nxt = CauseWdt;
          end else begin
            w_cause_nxt = CauseSw;
          end
        end
      end
      StAssert: begin
        if (r_pcnt == '0) begin
          w_state_nxt = StHold;
        end else begin
          w_pcnt_nxt = r_pcnt - PcntW'(1);
        end
      end
      StHold: begin
        // Wait for the button to be released so a held button yields one pulse.
        if (w_btn_level) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
    w_rst_req_nxt = (w_state_nxt == StAssert);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_pcnt    <= '0;
      r_wdt_cnt <= '0;
      r_cause   <= CauseNone;
      r_rst_req <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_wdt_cnt <= w_wdt_nxt;
      r_cause   <= w_cause_nxt;
      r_rst_req <= w_rst_req_nxt;
    end
  end

  assign o_rst_req = r_rst_req;
  assign o_cause   = r_cause;

endmodule

// File: tb/tb_rst_req.sv
// tb_rst_req
// Directed bench for rst_req with DEB_LEN=4, PULSE_LEN=3, WDT_LEN=10.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_rst_req;

  logic       clk;
  logic       rst_n;
  logic       i_btn_n;
  logic       i_sw_req;
  logic       i_wdt_en;
  logic       i_wdt_kick;
  logic       o_rst_req;
  logic [1:0] o_cause;

  int n_tests;
  int n_fail;
  logic seen;

  rst_req #(
    .DEB_LEN   (4),
    .PULSE_LEN (3),
    .WDT_LEN   (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn_n    (i_btn_n),
    .i_sw_req   (i_sw_req),
    .i_wdt_en   (i_wdt_en),
    .i_wdt_kick (i_wdt_kick),
    .o_rst_req  (o_rst_req),
    .o_cause    (o_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic exp);
    check(tag, {1'b0, o_rst_req}, {1'b0, exp});
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    seen       = 1'b0;
    rst_n      = 1'b0;
    i_btn_n    = 1'b1;
    i_sw_req   = 1'b0;
    i_wdt_en   = 1'b0;
    i_wdt_kick = 1'b0;

    // Reset state
    tick();
    tick();
    chk_req("reset_req", 1'b0);
    check("reset_cause", o_cause, 2'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk_req("idle_req", 1'b0);
    check("idle_cause", o_cause, 2'd0);

    // Software request: event window W, high W+1..W+3, low W+4
    i_sw_req = 1'b1;
    tick();
    i_sw_req = 1'b0;
    chk_req("sw_p1", 1'b1);
    check("sw_cause", o_cause, 2'd3);
    tick(); chk_req("sw_p2", 1'b1);
    tick(); chk_req("sw_p3", 1'b1);
    tick(); chk_req("sw_end", 1'b0);
    repeat (2) tick();

    // Button glitch of 3 cycles: never accepted
    i_btn_n = 1'b0;
    repeat (3) tick();
    i_btn_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_rst_req) seen = 1'b1;
      tick();
    end
    chk_req("glitch_no_req", seen);
    check("glitch_cause", o_cause, 2'd3);

    // Long button press starting window B, low for 10 cycles
    i_btn_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_rst_req) seen = 1'b1;
    end
    chk_req("btn_pre", seen);              // windows B+1..B+6
    tick(); chk_req("btn_p1", 1'b1);       // B+7
    check("btn_cause", o_cause, 2'd1);
    tick(); chk_req("btn_p2", 1'b1);
    tick(); chk_req("btn_p3", 1'b1);
    tick(); chk_req("btn_end", 1'b0);      // B+10, HOLD
    i_btn_n = 1'b1;
    repeat (6) tick();                     // B+16: debounced release, still HOLD
    i_sw_req = 1'b1;
    tick();                                // B+17: now IDLE
    chk_req("hold_sw_ignored", 1'b0);
    check("hold_cause", o_cause, 2'd1);
    tick();                                // B+18
    i_sw_req = 1'b0;
    chk_req("after_hold_sw", 1'b1);
    check("after_hold_cause", o_cause, 2'd3);
    repeat (3) tick();
    chk_req("after_hold_end", 1'b0);
    tick();

    // Watchdog without kicks: enable at window E, fire at E+9, high at E+10
    i_wdt_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (o_rst_req) seen = 1'b1;
    end
    chk_req("wdt_pre", seen);
    tick();
    i_wdt_en = 1'b0;
    chk_req("wdt_p1", 1'b1);
    check("wdt_cause", o_cause, 2'd2);
    tick(); chk_req("wdt_p2", 1'b1);
    tick(); chk_req("wdt_p3", 1'b1);
    tick(); chk_req("wdt_end", 1'b0);
    repeat (2) tick();

    // Kicks every 8 cycles for 200 cycles: no request
    i_wdt_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      i_wdt_kick = ((i % 8) == 7);
      if (o_rst_req) seen = 1'b1;
      tick();
    end
    i_wdt_kick = 1'b0;
    i_wdt_en = 1'b0;
    chk_req("kick_no_req", seen);
    tick();

    // Kick in the expiry cycle wins; then expiry coincides with sw_req
    i_wdt_en = 1'b1;                       // window E
    repeat (9) tick();                     // E+9, counter at 9
    i_wdt_kick = 1'b1;
    tick();                                // E+10
    i_wdt_kick = 1'b0;
    chk_req("kick_same_cycle", 1'b0);
    repeat (9) tick();                     // E+19, counter at 9 again
    chk_req("wdt2_pre", 1'b0);
    i_sw_req = 1'b1;
    tick();                                // E+20
    i_sw_req = 1'b0;
    i_wdt_en = 1'b0;
    chk_req("both_p1", 1'b1);
    check("both_cause", o_cause, 2'd2);
    tick();                                // E+21, sw_req during ASSERT
    i_sw_req = 1'b1;
    chk_req("both_p2", 1'b1);
    tick();
    i_sw_req = 1'b0;
    chk_req("both_p3", 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_rst_req) seen = 1'b1;
    end
    chk_req("no_second_pulse", seen);
    check("both_cause_hold", o_cause, 2'd2);

    // Reset asserted mid-pulse
    i_sw_req = 1'b1;
    tick();
    i_sw_req = 1'b0;
    chk_req("rst_pre_pulse", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_req("rst_async_req", 1'b0);
    check("rst_async_cause", o_cause, 2'd0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_rst_req) seen = 1'b1;
    end
    chk_req("rst_no_resume", seen);
    check("rst_cause_after", o_cause, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_req.md
RST_REQ -- requirements
Module: rst_req

Interface
Parameters:
REQ-001 DEB_LEN, 50000, consecutive stable clk cycles (≥2) before a synchronized button level is accepted.
REQ-002 PULSE_LEN, 16, clk cycles rst_req is held high per request (≥1).
REQ-003 WDT_LEN, 12000000, clk cycles without a kick before a watchdog request (≥2).
Ports:
REQ-004 clk  in  1  raw board oscillator clock, not PLL output, so it keeps running while rst_req resets the PLL.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 btn_n  in  1  raw asynchronous user button, active-low.
REQ-007 sw_req  in  1  single-cycle software reset request, synchronous to clk.
REQ-008 wdt_en  in  1  watchdog enable level, synchronous.
REQ-009 wdt_kick  in  1  single-cycle watchdog reload, synchronous.
REQ-010 rst_req  out  1  active-high reset request to the system reset manager's reset input, registered.
REQ-011 cause  out  2  last reset cause: 0 none, 1 button, 2 watchdog, 3 software; registered.

Function
REQ-012 btn_n SHALL pass a 2-flop synchronizer; flops initialize to 1.
REQ-013 Debounced button level SHALL change only after the synchronized level differs from it for DEB_LEN consecutive cycles; any glitch restarts the count.
REQ-014 Button event SHALL be the debounced 1->0 transition.
REQ-015 Watchdog counter SHALL count up while wdt_en=1 and FSM is IDLE, clear to 0 on wdt_kick, on wdt_en=0, and outside IDLE.
REQ-016 Watchdog event SHALL fire in the cycle the counter reaches WDT_LEN-1 with no kick that cycle; a kick in the same cycle wins.
REQ-017 FSM states: IDLE, ASSERT, HOLD.
REQ-018 IDLE: any event (button, watchdog, sw_req) SHALL go to ASSERT next cycle, load pulse counter, latch cause.
REQ-019 Simultaneous events SHALL resolve by priority button > watchdog > software; only the winner is recorded.
REQ-020 ASSERT: rst_req=1 for exactly PULSE_LEN cycles, starting the cycle after the event; then HOLD.
REQ-021 HOLD: rst_req=0; SHALL return to IDLE once the debounced button is released (1); otherwise immediately next cycle.
REQ-022 Events occurring in ASSERT or HOLD SHALL be ignored and not queued; sw_req and wdt_kick have no effect there.
REQ-023 cause SHALL hold its value until the next accepted event; never cleared except by rst_n.
REQ-024 Request latency: event cycle N -> rst_req high at N+1, low at N+1+PULSE_LEN.

Reset
REQ-025 rst_n low SHALL asynchronously force: FSM IDLE, rst_req=0, cause=0, all counters 0, synchronizer and debounced level 1.
REQ-026 rst_n release mid-pulse SHALL NOT resume a pulse; the block restarts from IDLE.
REQ-027 rst_n SHALL be driven from a source independent of rst_req so the block does not reset itself.

Structure
REQ-028 Cause encodings and state encodings SHALL live in a shared include/constants header.
REQ-029 Synchronizer plus debounce SHALL be one sub-module, rst_req_debounce (clk, rst_n, in_n, level, fall).
REQ-030 Counter widths SHALL derive from parameters; no hard-coded widths.

Verification (DEB_LEN=4, PULSE_LEN=3, WDT_LEN=10)
REQ-031 sw_req pulse at cycle 20 -> rst_req high cycles 21-23, low 24; cause=3.
REQ-032 btn_n low 3 cycles then high -> no event; btn_n low 10 cycles -> rst_req 3-cycle pulse, cause=1, FSM stays in HOLD until button is released and debounced, then IDLE.
REQ-033 wdt_en=1, no kicks -> rst_req rises 10 cycles after enable, cause=2; kicks every 8 cycles -> rst_req never asserts over 200 cycles.
REQ-034 sw_req and watchdog expiry in the same cycle -> single pulse, cause=2; sw_req during ASSERT -> no second pulse.
REQ-035 rst_n asserted during ASSERT -> rst_req=0 immediately, cause=0; after release, no pulse without a new event.
